// File: rtl/io_buffer_arbiter.sv
// Two-requester round-robin arbiter in front of an external LIFO stack.
// Tracks occupancy, issues one push/pop strobe per grant and returns popped words in grant order.
module io_buffer_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int STACK_SIZE = 256,
    parameter int CNT_W      = $clog2(STACK_SIZE + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req0_valid,
    input  logic                  i_req0_pop,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    output logic                  o_req0_ready,
    input  logic                  i_req1_valid,
    input  logic                  i_req1_pop,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic                  o_req1_ready,
    output logic                  o_rd_valid,
    output logic                  o_rd_id,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_push_cmd,
    output logic                  o_pop_cmd,
    output logic [DATA_WIDTH-1:0] o_stack_data,
    input  logic [DATA_WIDTH-1:0] i_stack_data,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STACK_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [1:0]            elig_s;
    logic [1:0]            grant_s;
    logic                  grant_any_s;
    logic                  grant_id_s;
    logic                  grant_pop_s;
    logic [DATA_WIDTH-1:0] grant_data_s;
    logic                  full_s;
    logic                  empty_s;

    logic                  rr_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_cmd_r;
    logic                  pop_cmd_r;
    logic                  pop_id_r;
    logic                  rd_valid_r;
    logic                  rd_id_r;
    logic [DATA_WIDTH-1:0] stack_data_r;

    assign full_s  = (count_r == CNT_MAX);
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Eligibility and round-robin pick; nothing is granted while reset is held.
    always_comb begin
        elig_s[0] = i_req0_valid && (i_req0_pop ? !empty_s : !full_s);
        elig_s[1] = i_req1_valid && (i_req1_pop ? !empty_s : !full_s);
        grant_s   = 2'b00;
        if (!i_rst_n) begin
            grant_s = 2'b00;
        end else if (elig_s == 2'b11) begin
            grant_s = rr_ptr_r ? 2'b10 : 2'b01;
        end else begin
            grant_s = elig_s;
        end
    end

    // Select the winning requester's command.
    always_comb begin
        grant_any_s = |grant_s;
        grant_id_s  = grant_s[1];
        if (grant_s[1]) begin
            grant_pop_s  = i_req1_pop;
            grant_data_s = i_req1_data;
        end else begin
            grant_pop_s  = i_req0_pop;
            grant_data_s = i_req0_data;
        end
    end

    // Round-robin pointer and occupancy, both updated at the end of the grant cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (grant_any_s) begin
                rr_ptr_r <= ~grant_id_s;
                if (grant_pop_s) begin
                    count_r <= count_r - CNT_ONE;
                end else begin
                    count_r <= count_r + CNT_ONE;
                end
            end
        end
    end

    // Strobe stage one cycle after grant, return stage two cycles after a pop grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            push_cmd_r   <= 1'b0;
            pop_cmd_r    <= 1'b0;
            pop_id_r     <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_id_r      <= 1'b0;
            stack_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            push_cmd_r <= grant_any_s && !grant_pop_s;
            pop_cmd_r  <= grant_any_s && grant_pop_s;
            pop_id_r   <= grant_id_s;
            rd_valid_r <= pop_cmd_r;
            rd_id_r    <= pop_id_r;
            if (grant_any_s && !grant_pop_s) begin
                stack_data_r <= grant_data_s;
            end
        end
    end

    assign o_req0_ready = grant_s[0];
    assign o_req1_ready = grant_s[1];
    assign o_push_cmd   = push_cmd_r;
    assign o_pop_cmd    = pop_cmd_r;
    assign o_stack_data = stack_data_r;
    assign o_rd_valid   = rd_valid_r;
    assign o_rd_id      = rd_id_r;
    assign o_rd_data    = i_stack_data;
    assign o_count      = count_r;
    assign o_full       = full_s;
    assign o_empty      = empty_s;

endmodule
